// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
// Watches a core's hsync/vsync/rgb output and measures every frame: active
// pixels per line, active lines per frame and an rgb checksum. Raises
// per-frame and sticky timing-error flags and reports lock once frames match
// the expected resolution.
`timescale 1ns/1ps
module vga_frame_monitor #(
  parameter int unsigned RGB_W      = 3,
  parameter int unsigned SAMPLE_DIV = 2,
  parameter logic        SYNC_ACT   = 1'b0,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned SUM_W      = 24,
  parameter int unsigned FRM_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [RGB_W-1:0] rgb,
  input  logic             clr,
  output logic             frame_done,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] line_cnt,
  output logic [SUM_W-1:0] frame_sum,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             err_h,
  output logic             err_v,
  output logic             err_sticky,
  output logic             locked
);

  localparam int unsigned      DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic             SYNC_IDLE = ~SYNC_ACT;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] H_EXP     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_EXP     = CNT_W'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t             state;

  logic               hs_r, vs_r, hs_p, vs_p;
  logic [RGB_W-1:0]   rgb_r;
  logic [DIV_W-1:0]   div;
  logic [CNT_W-1:0]   pix_cnt;
  logic [CNT_W-1:0]   lines;
  logic [SUM_W-1:0]   sum;
  logic               fh;

  logic               hs_edge, vs_edge;
  logic               sample;
  logic               line_close;
  logic               frame_end;
  logic [CNT_W-1:0]   lines_nxt;
  logic               fh_nxt;
  logic               new_err_v;
  logic               frame_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Register the raw video inputs once, and keep the previous sync levels
  // for assertion-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_r  <= SYNC_IDLE;
      vs_r  <= SYNC_IDLE;
      hs_p  <= SYNC_IDLE;
      vs_p  <= SYNC_IDLE;
      rgb_r <= '0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_p  <= hs_r;
      vs_p  <= vs_r;
      rgb_r <= rgb;
    end
  end

  // Edge decode, pixel strobe and the line/frame closing terms. A line closed
  // on the same cycle as a vsync edge is folded into the frame being closed,
  // so the frame results use the *_nxt values rather than the registers.
  always_comb begin
    hs_edge    = 1'b0;
    vs_edge    = 1'b0;
    sample     = 1'b0;
    line_close = 1'b0;
    frame_end  = 1'b0;
    lines_nxt  = lines;
    fh_nxt     = fh;
    new_err_v  = 1'b0;
    frame_err  = 1'b0;

    hs_edge    = (hs_p != SYNC_ACT) && (hs_r == SYNC_ACT);
    vs_edge    = (vs_p != SYNC_ACT) && (vs_r == SYNC_ACT);
    sample     = (div == '0) && (hs_r != SYNC_ACT) && (vs_r != SYNC_ACT) &&
                 (state != S_WAIT);
    line_close = hs_edge && (pix_cnt != '0);
    frame_end  = vs_edge && (state != S_WAIT);

    if (line_close) begin
      lines_nxt = sat_inc(lines);
      if (pix_cnt != H_EXP) fh_nxt = 1'b1;
    end
    new_err_v = (lines_nxt != V_EXP);
    frame_err = fh_nxt | new_err_v;
  end

  // Pixel-rate divider, realigned to the start of every line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (hs_edge || div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Per-line and per-frame accumulators; any vsync edge starts a fresh frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt <= '0;
      lines   <= '0;
      sum     <= '0;
      fh      <= 1'b0;
    end else if (vs_edge) begin
      pix_cnt <= '0;
      lines   <= '0;
      sum     <= '0;
      fh      <= 1'b0;
    end else begin
      if (hs_edge) begin
        pix_cnt <= '0;
      end else if (sample) begin
        pix_cnt <= sat_inc(pix_cnt);
      end
      if (sample) sum <= sum + SUM_W'(rgb_r);
      lines <= lines_nxt;
      fh    <= fh_nxt;
    end
  end

  // Latch the measured results at line end and frame end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_len   <= '0;
      line_cnt   <= '0;
      frame_sum  <= '0;
      err_h      <= 1'b0;
      err_v      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (line_close) line_len <= pix_cnt;
      if (frame_end) begin
        line_cnt  <= lines_nxt;
        frame_sum <= sum;
        err_h     <= fh_nxt;
        err_v     <= new_err_v;
      end
    end
  end

  // Frame counter and sticky error; clr takes priority over a frame end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt  <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      frame_cnt  <= '0;
      err_sticky <= 1'b0;
    end else if (frame_end) begin
      frame_cnt  <= frame_cnt + FRM_W'(1);
      err_sticky <= err_sticky | frame_err;
    end
  end

  // Lock tracking: wait for the first vsync, then lock on a clean frame and
  // drop back to acquisition on any bad one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_WAIT;
    end else begin
      case (state)
        S_WAIT:  if (vs_edge) state <= S_ACQ;
        S_ACQ:   if (frame_end && !frame_err) state <= S_LOCK;
        S_LOCK:  if (frame_end && frame_err) state <= S_ACQ;
        default: state <= S_WAIT;
      endcase
    end
  end

  // Lock status straight from the state register.
  always_comb begin
    locked = (state == S_LOCK);
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor
// Drives synthetic video frames (line pixel counts and pixel values held in
// queues) into vga_frame_monitor and compares every frame report with a
// frame-level reference computed from those queues.
`timescale 1ns/1ps
module tb_vga_frame_monitor;

  localparam int unsigned RGB_W = 3;
  localparam int unsigned DIV   = 2;
  localparam int unsigned H_ACT = 4;
  localparam int unsigned V_ACT = 3;
  localparam int unsigned CNT_W = 12;
  localparam int unsigned SUM_W = 24;
  localparam int unsigned FRM_W = 16;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;
  localparam int unsigned FMASK = (1 << FRM_W) - 1;

  typedef struct packed {
    logic [CNT_W-1:0] line_len;
    logic [CNT_W-1:0] line_cnt;
    logic [SUM_W-1:0] frame_sum;
    logic             err_h;
    logic             err_v;
    logic             err_sticky;
    logic             locked;
    logic [FRM_W-1:0] frame_cnt;
    logic [7:0]       fd_n;
    logic [7:0]       fd_lat;
  } res_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             hsync = 1'b1;
  logic             vsync = 1'b1;
  logic             clr = 1'b0;
  logic [RGB_W-1:0] rgb = '0;
  logic             frame_done;
  logic [CNT_W-1:0] line_len, line_cnt;
  logic [SUM_W-1:0] frame_sum;
  logic [FRM_W-1:0] frame_cnt;
  logic             err_h, err_v, err_sticky, locked;

  vga_frame_monitor #(
    .RGB_W(RGB_W), .SAMPLE_DIV(DIV), .SYNC_ACT(1'b0), .H_ACTIVE(H_ACT),
    .V_ACTIVE(V_ACT), .CNT_W(CNT_W), .SUM_W(SUM_W), .FRM_W(FRM_W)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .clr(clr), .frame_done(frame_done), .line_len(line_len),
    .line_cnt(line_cnt), .frame_sum(frame_sum), .frame_cnt(frame_cnt),
    .err_h(err_h), .err_v(err_v), .err_sticky(err_sticky), .locked(locked)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned vs_cyc = 0;
  int unsigned fd_count = 0;
  int unsigned fd_cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // frame_done pulse monitor: counts high cycles and records when.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_cyc = cyc;
    end
  end

  // Reference model state (frame-level quantities only).
  int unsigned m_line_len, m_frame_cnt;
  bit          m_sticky, m_locked;
  res_t        m_prev;
  int unsigned fr_n[$];
  int unsigned fr_v[$];

  function automatic res_t observe(input int unsigned base);
    res_t o;
    o.line_len   = line_len;
    o.line_cnt   = line_cnt;
    o.frame_sum  = frame_sum;
    o.err_h      = err_h;
    o.err_v      = err_v;
    o.err_sticky = err_sticky;
    o.locked     = locked;
    o.frame_cnt  = frame_cnt;
    o.fd_n       = 8'(fd_count - base);
    o.fd_lat     = (fd_count == base) ? 8'd0 : 8'(fd_cyc - vs_cyc);
    return o;
  endfunction

  function automatic void model_reset();
    m_line_len  = 0;
    m_frame_cnt = 0;
    m_sticky    = 1'b0;
    m_locked    = 1'b0;
    m_prev      = '0;
  endfunction

  // Expected outputs when no frame was reported: previous report, no pulse.
  function automatic res_t idle_exp();
    res_t e;
    e        = m_prev;
    e.fd_n   = 8'd0;
    e.fd_lat = 8'd0;
    return e;
  endfunction

  // Frame report expected from the line/pixel queues of the frame just sent.
  function automatic res_t model_frame(input bit clr_hit);
    res_t            e;
    int unsigned     cnt = 0;
    int unsigned     vi = 0;
    longint unsigned s = 0;
    bit              eh = 1'b0;
    bit              ev, err;
    foreach (fr_n[i]) begin
      cnt++;
      m_line_len = (fr_n[i] > CMAX) ? CMAX : fr_n[i];
      if (fr_n[i] != H_ACT) eh = 1'b1;
      for (int p = 0; p < int'(fr_n[i]); p++) begin
        s += fr_v[vi];
        vi++;
      end
    end
    if (cnt > CMAX) cnt = CMAX;
    ev  = (cnt != V_ACT);
    err = eh | ev;
    m_frame_cnt = clr_hit ? 0 : ((m_frame_cnt + 1) & FMASK);
    m_sticky    = clr_hit ? 1'b0 : (m_sticky | err);
    m_locked    = !err;
    e.line_len   = CNT_W'(m_line_len);
    e.line_cnt   = CNT_W'(cnt);
    e.frame_sum  = SUM_W'(s);
    e.err_h      = eh;
    e.err_v      = ev;
    e.err_sticky = m_sticky;
    e.locked     = m_locked;
    e.frame_cnt  = FRM_W'(m_frame_cnt);
    e.fd_n       = 8'd1;
    e.fd_lat     = 8'd2;
    m_prev       = e;
    return e;
  endfunction

  task automatic drive(input logic h, input logic v, input logic c, input int unsigned r);
    @(negedge clk);
    hsync = h;
    vsync = v;
    clr   = c;
    rgb   = RGB_W'(r);
  endtask

  // One line: single-clock hsync pulse, then each pixel held DIV clocks with
  // only the first clock carrying the real value.
  task automatic send_line(input int unsigned n, inout int unsigned vi);
    drive(1'b0, 1'b1, 1'b0, $urandom);
    for (int unsigned p = 0; p < n; p++) begin
      drive(1'b1, 1'b1, 1'b0, fr_v[vi]);
      vi++;
      for (int unsigned k = 1; k < DIV; k++) drive(1'b1, 1'b1, 1'b0, $urandom);
    end
  endtask

  task automatic send_lines();
    int unsigned vi = 0;
    foreach (fr_n[i]) send_line(fr_n[i], vi);
  endtask

  // Close the last line (optionally on the vsync edge itself), then vertical
  // blanking with two empty lines. clr_hit lands on the frame-end cycle.
  task automatic send_vsync(input bit same, input bit clr_hit);
    if (same) begin
      drive(1'b0, 1'b0, 1'b0, $urandom);
    end else begin
      drive(1'b0, 1'b1, 1'b0, $urandom);
      drive(1'b1, 1'b0, 1'b0, $urandom);
    end
    vs_cyc = cyc;
    drive(1'b1, 1'b0, clr_hit, $urandom);
    repeat (2) begin
      drive(1'b1, 1'b0, 1'b0, $urandom);
      drive(1'b0, 1'b0, 1'b0, $urandom);
      drive(1'b1, 1'b0, 1'b0, $urandom);
    end
    drive(1'b1, 1'b0, 1'b0, $urandom);
  endtask

  task automatic fill_frame(input int unsigned nl, input int unsigned n, input int unsigned v);
    fr_n.delete();
    fr_v.delete();
    repeat (nl) begin
      fr_n.push_back(n);
      repeat (n) fr_v.push_back(v);
    end
  endtask

  task automatic test_reset();
    res_t got;
    repeat (3) @(negedge clk);
    got = observe(fd_count);
    vectors++;
    if (got !== res_t'('0)) begin
      miscompares++;
      $display("FAIL reset_hold got=%h exp=%h", got, res_t'('0));
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    got = observe(fd_count);
    vectors++;
    if (got !== res_t'('0)) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", got, res_t'('0));
    end
  endtask

  task automatic test_lead_in();
    res_t got, exp;
    int unsigned base;
    fill_frame(2, 4, 5);
    base = fd_count;
    send_lines();
    send_vsync(1'b0, 1'b0);
    got = observe(base);
    exp = idle_exp();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL lead_in got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_basic();
    res_t got, exp;
    int unsigned base;
    for (int f = 0; f < 3; f++) begin
      fill_frame(3, 4, (f == 2) ? 7 : 1);
      base = fd_count;
      send_lines();
      send_vsync(1'b0, 1'b0);
      got = observe(base);
      exp = model_frame(1'b0);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL basic_frame%0d got=%h exp=%h", f, got, exp);
      end
    end
    vectors++;
    if (frame_sum !== 24'd84) begin
      miscompares++;
      $display("FAIL basic_sum84 got=%0d exp=84", frame_sum);
    end
  endtask

  task automatic test_err_h();
    res_t got, exp;
    int unsigned base;
    for (int f = 0; f < 2; f++) begin
      fill_frame(3, 4, 2);
      if (f == 0) begin
        fr_n[1] = 5;
        fr_v.push_back(3);
      end
      base = fd_count;
      send_lines();
      send_vsync(1'b0, 1'b0);
      got = observe(base);
      exp = model_frame(1'b0);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL err_h_frame%0d got=%h exp=%h", f, got, exp);
      end
    end
  endtask

  task automatic test_err_v_clr();
    res_t got, exp;
    int unsigned base;
    fill_frame(2, 4, 3);
    base = fd_count;
    send_lines();
    send_vsync(1'b0, 1'b1);
    got = observe(base);
    exp = model_frame(1'b1);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL err_v_clr got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_clr_idle();
    res_t got, exp;
    int unsigned base;
    fill_frame(4, 4, 6);
    base = fd_count;
    send_lines();
    send_vsync(1'b0, 1'b0);
    exp = model_frame(1'b0);
    drive(1'b1, 1'b0, 1'b1, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    m_sticky       = 1'b0;
    m_frame_cnt    = 0;
    exp.err_sticky = 1'b0;
    exp.frame_cnt  = '0;
    m_prev         = exp;
    got = observe(base);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL clr_idle got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_same_cycle();
    res_t got, exp;
    int unsigned base;
    fill_frame(3, 4, 4);
    base = fd_count;
    send_lines();
    send_vsync(1'b1, 1'b0);
    got = observe(base);
    exp = model_frame(1'b0);
    vectors++;
    if (got !== exp || line_cnt !== 12'd3) begin
      miscompares++;
      $display("FAIL same_cycle got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_saturation();
    res_t got, exp;
    int unsigned base;
    fr_n.delete();
    fr_v.delete();
    fr_n.push_back(CMAX + 5);
    repeat (CMAX + 5) fr_v.push_back($urandom_range(0, 7));
    base = fd_count;
    send_lines();
    send_vsync(1'b0, 1'b0);
    got = observe(base);
    exp = model_frame(1'b0);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL pix_saturation got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_random();
    res_t        got, exp;
    int unsigned base, nl, n;
    bit          same, ch;
    int unsigned ntab[6] = '{1, 3, 4, 4, 4, 5};
    for (int f = 0; f < 14; f++) begin
      fr_n.delete();
      fr_v.delete();
      nl = (f < 2) ? 3 : $urandom_range(0, 5);
      for (int unsigned l = 0; l < nl; l++) begin
        n = ntab[$urandom_range(0, 5)];
        fr_n.push_back(n);
        repeat (n) fr_v.push_back($urandom_range(0, 7));
      end
      same = (nl > 0) && ($urandom_range(0, 1) == 1);
      ch   = ($urandom_range(0, 3) == 0);
      base = fd_count;
      send_lines();
      send_vsync(same, ch);
      got = observe(base);
      exp = model_frame(ch);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_frame%0d got=%h exp=%h", f, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t        got, exp;
    int unsigned base;
    drive(1'b0, 1'b1, 1'b0, 0);
    repeat (5) drive(1'b1, 1'b1, 1'b0, $urandom);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    got = observe(fd_count);
    vectors++;
    if (got !== res_t'('0)) begin
      miscompares++;
      $display("FAIL reset_mid got=%h exp=%h", got, res_t'('0));
    end
    model_reset();
    reset = 1'b1;
    fill_frame(2, 4, 6);
    base = fd_count;
    send_lines();
    send_vsync(1'b0, 1'b0);
    got = observe(base);
    exp = idle_exp();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_mid_ignored got=%h exp=%h", got, exp);
    end
    fill_frame(3, 4, 2);
    base = fd_count;
    send_lines();
    send_vsync(1'b0, 1'b0);
    got = observe(base);
    exp = model_frame(1'b0);
    vectors++;
    if (got !== exp || frame_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL reset_mid_resume got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lead_in();
    test_basic();
    test_err_h();
    test_err_v_clr();
    test_clr_idle();
    test_same_cycle();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
